// File: rtl/logic_axi4_stream_packet_queue_if.sv
// logic_axi4_stream_if: AXI4-Stream bundle; rx modport is the sink side, tx modport the source side
interface logic_axi4_stream_if #(
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH = 1
);
  logic tvalid;
  logic tready;
  logic tlast;
  logic [TDATA_BYTES*8-1:0] tdata;
  logic [TDATA_BYTES-1:0] tkeep;
  logic [TDATA_BYTES-1:0] tstrb;
  logic [TID_WIDTH-1:0] tid;
  logic [TDEST_WIDTH-1:0] tdest;
  logic [TUSER_WIDTH-1:0] tuser;
  modport rx (input tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, output tready);
  modport tx (output tvalid, tdata, tkeep, tstrb, tlast, tid, tdest, tuser, input tready);
endinterface

// File: rtl/logic_axi4_stream_packet_queue.sv
// logic_axi4_stream_packet_queue: store-and-forward AXI4-Stream packet FIFO; define LOGIC_AXI4_STREAM_PACKET_QUEUE_DROP_EN to discard errored/oversize packets
package logic_pkg;
  typedef enum logic [1:0] {TARGET_GENERIC, TARGET_XILINX, TARGET_INTEL} target_e;
endpackage

module logic_axi4_stream_packet_queue #(
  parameter logic_pkg::target_e TARGET = logic_pkg::TARGET_GENERIC,
  parameter int TDATA_BYTES = 1,
  parameter int TDEST_WIDTH = 1,
  parameter int TUSER_WIDTH = 1,
  parameter int TID_WIDTH = 1,
  parameter bit USE_TKEEP = 1'b1,
  parameter bit USE_TSTRB = 1'b1,
  parameter int CAPACITY = 256,
  parameter int MAX_PACKETS = 16
) (
  input logic aclk,
  input logic areset_n,
  logic_axi4_stream_if.rx rx,
  logic_axi4_stream_if.tx tx
);
  localparam int PW = $clog2(CAPACITY);
  localparam int FW = $clog2(CAPACITY + 1);
  localparam int CW = $clog2(MAX_PACKETS + 1);
  typedef enum logic [1:0] {STORE, FORCE, DROP} state_e;
  typedef struct packed {
    logic [TUSER_WIDTH-1:0] tuser;
    logic [TDEST_WIDTH-1:0] tdest;
    logic [TID_WIDTH-1:0] tid;
    logic tlast;
    logic [TDATA_BYTES-1:0] tkeep;
    logic [TDATA_BYTES-1:0] tstrb;
    logic [TDATA_BYTES*8-1:0] tdata;
  } beat_t;
  state_e state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, pkt_start_ptr_q, pkt_start_ptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic rx_ready_q, rx_ready_d;
  logic wr_fire, rd_fire, wr_en, bad_last, tx_valid;
  beat_t wr_beat, rd_beat;
`ifdef LOGIC_AXI4_STREAM_PACKET_QUEUE_DROP_EN
  logic [PW-1:0] part_len;
`endif
  assign wr_beat = {rx.tuser, rx.tdest, rx.tid, rx.tlast, rx.tkeep, rx.tstrb, rx.tdata};
  // beat storage with first-word fall-through read; vendor targets get a LUT-RAM hint since the read is asynchronous
  if (TARGET == logic_pkg::TARGET_GENERIC) begin : g_mem
    beat_t mem [CAPACITY];
    // write port
    always_ff @(posedge aclk) if (wr_en) mem[wr_ptr_q] <= wr_beat;
    assign rd_beat = mem[rd_ptr_q];
  end else begin : g_mem_lut
    (* ram_style = "distributed" *) beat_t mem [CAPACITY];
    // write port
    always_ff @(posedge aclk) if (wr_en) mem[wr_ptr_q] <= wr_beat;
    assign rd_beat = mem[rd_ptr_q];
  end
  assign rx.tready = rx_ready_q;
  assign tx.tvalid = tx_valid;
  assign tx.tdata = rd_beat.tdata;
  assign tx.tkeep = USE_TKEEP ? rd_beat.tkeep : '1;
  assign tx.tstrb = USE_TSTRB ? rd_beat.tstrb : '1;
  assign tx.tlast = rd_beat.tlast;
  assign tx.tid = rd_beat.tid;
  assign tx.tdest = rd_beat.tdest;
  assign tx.tuser = rd_beat.tuser;
  // pointer/fill/packet bookkeeping, store/force/drop FSM and next rx ready
  always_comb begin
    tx_valid = (pkt_count_q != '0 || state_q == FORCE) && fill_q != '0;
    wr_fire = rx.tvalid && rx_ready_q;
    rd_fire = tx_valid && tx.tready;
    bad_last = 1'b0;
`ifdef LOGIC_AXI4_STREAM_PACKET_QUEUE_DROP_EN
    part_len = wr_ptr_q - pkt_start_ptr_q;
    bad_last = wr_fire && rx.tlast && rx.tuser[0] && state_q == STORE;
`endif
    wr_en = wr_fire && state_q != DROP && !bad_last;
    state_d = state_q;
    wr_ptr_d = wr_ptr_q + PW'(wr_en);
    rd_ptr_d = rd_ptr_q + PW'(rd_fire);
    fill_d = fill_q + FW'(wr_en) - FW'(rd_fire);
    pkt_count_d = pkt_count_q + CW'(wr_en && rx.tlast) - CW'(rd_fire && rd_beat.tlast);
    pkt_start_ptr_d = wr_en && rx.tlast ? wr_ptr_q + 1'b1 : pkt_start_ptr_q;
`ifdef LOGIC_AXI4_STREAM_PACKET_QUEUE_DROP_EN
    if (bad_last) begin
      wr_ptr_d = pkt_start_ptr_q;
      fill_d = fill_q - FW'(part_len) - FW'(rd_fire);
    end
    if (state_q == STORE && fill_q == FW'(CAPACITY) && pkt_count_q == '0) begin
      state_d = DROP;
      wr_ptr_d = pkt_start_ptr_q;
      fill_d = '0;
    end
    if (state_q == DROP && wr_fire && rx.tlast) state_d = STORE;
`else
    if (state_q == STORE && fill_q == FW'(CAPACITY) && pkt_count_q == '0) state_d = FORCE;
    if (state_q == FORCE && rd_fire && rd_beat.tlast) state_d = STORE;
`endif
    rx_ready_d = state_d == DROP || (fill_d < FW'(CAPACITY) && pkt_count_d < CW'(MAX_PACKETS));
  end
  // state registers; reset discards everything stored
  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      state_q <= STORE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      pkt_start_ptr_q <= '0;
      fill_q <= '0;
      pkt_count_q <= '0;
      rx_ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      pkt_start_ptr_q <= pkt_start_ptr_d;
      fill_q <= fill_d;
      pkt_count_q <= pkt_count_d;
      rx_ready_q <= rx_ready_d;
    end
  end
endmodule
